// File: rtl/regbank_arbiter_pkg.sv
// rtl/regbank_arbiter_pkg.sv - shared widths and arbiter state encodings for regbank_arbiter
package regbank_arbiter_pkg;
  localparam int WORD    = 32;
  localparam int CYCLE   = 10;
  localparam int WRCNT_W = 16;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_t;
endpackage

// File: rtl/regbank_arbiter_register.sv
// rtl/regbank_arbiter_register.sv - single bank entry, D flip-flop word with async clear
module register #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= '0;
    else       q <= d;
  end
endmodule

// File: rtl/regbank_arbiter.sv
// rtl/regbank_arbiter.sv - round-robin burst arbiter sharing a register bank between two writers
module regbank_arbiter
  import regbank_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 2,
  parameter int TIMEOUT = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0_valid,
  input  logic [ADDR_W-1:0]  req0_addr,
  input  logic [WORD-1:0]    req0_data,
  input  logic               req0_last,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [ADDR_W-1:0]  req1_addr,
  input  logic [WORD-1:0]    req1_data,
  input  logic               req1_last,
  output logic               req1_ready,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [WORD-1:0]    rd_data,
  output logic               busy,
  output logic               owner,
  output logic [WRCNT_W-1:0] wr_count
);
  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam int WD_W     = $clog2(TIMEOUT + 1);

  arb_state_t        state_q, state_d;
  logic              rr_q, rr_d;
  logic              owner_q, owner_d;
  logic [WD_W-1:0]   wd_q, wd_d, wd_inc;
  logic              accept;
  logic              cur_valid, cur_last;
  logic [ADDR_W-1:0] waddr;
  logic [WORD-1:0]   wdata;
  logic [WORD-1:0]   q [NUM_REGS];

  // Owner-side beat fields; only meaningful while in an OWN state.
  assign cur_valid = (state_q == ARB_OWN1) ? req1_valid : req0_valid;
  assign cur_last  = (state_q == ARB_OWN1) ? req1_last  : req0_last;
  assign waddr     = (state_q == ARB_OWN1) ? req1_addr  : req0_addr;
  assign wdata     = (state_q == ARB_OWN1) ? req1_data  : req0_data;
  assign wd_inc    = wd_q + WD_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ARB_IDLE;
      rr_q     <= 1'b0;
      owner_q  <= 1'b0;
      wd_q     <= '0;
      wr_count <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      wd_q    <= wd_d;
      if (accept) wr_count <= wr_count + WRCNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    wd_d    = wd_q;
    accept  = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        wd_d = '0;
        if (req0_valid && (!req1_valid || !rr_q)) begin
          state_d = ARB_OWN0;
          owner_d = 1'b0;
        end else if (req1_valid) begin
          state_d = ARB_OWN1;
          owner_d = 1'b1;
        end
      end
      ARB_OWN0, ARB_OWN1: begin
        if (cur_valid) begin
          accept = 1'b1;
          wd_d   = '0;
          if (cur_last) begin
            state_d = ARB_IDLE;
            rr_d    = ~owner_q;
          end
        end else if (wd_inc == WD_W'(TIMEOUT)) begin
          // Stalled owner: reclaim the bank, keep beats already written.
          state_d = ARB_IDLE;
          rr_d    = ~owner_q;
          wd_d    = '0;
        end else begin
          wd_d = wd_inc;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign req0_ready = (state_q == ARB_OWN0);
  assign req1_ready = (state_q == ARB_OWN1);
  assign busy       = (state_q != ARB_IDLE);
  assign owner      = owner_q;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_bank
    logic we;
    logic [WORD-1:0] d;
    assign we = accept && (waddr == ADDR_W'(i));
    assign d  = we ? wdata : q[i];
    register #(.W(WORD)) u_reg (
      .clk   (clk),
      .reset (reset),
      .d     (d),
      .q     (q[i])
    );
  end

  assign rd_data = q[rd_addr];
endmodule

// File: tb/tb_regbank_arbiter.sv
// tb/tb_regbank_arbiter.sv - directed self-checking bench for regbank_arbiter
module tb_regbank_arbiter;
  import regbank_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_last, req0_ready;
  logic [1:0]  req0_addr;
  logic [31:0] req0_data;
  logic        req1_valid, req1_last, req1_ready;
  logic [1:0]  req1_addr;
  logic [31:0] req1_data;
  logic [1:0]  rd_addr;
  logic [31:0] rd_data;
  logic        busy, owner;
  logic [15:0] wr_count;

  int total = 0;
  int bad   = 0;

  always #(CYCLE / 2) clk = ~clk;

  regbank_arbiter #(.ADDR_W(2), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data),
    .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data),
    .req1_last(req1_last), .req1_ready(req1_ready),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .owner(owner), .wr_count(wr_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req0_valid = 0; req0_addr = 0; req0_data = 0; req0_last = 0;
    req1_valid = 0; req1_addr = 0; req1_data = 0; req1_last = 0;
    rd_addr = 0;
    reset = 1;
    tick();
    reset = 0;
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] exp_rd [4];
    exp_rd = '{32'h0, 32'h0, 32'h0, 32'h0};
    do_reset();
    for (int a = 0; a < 4; a++) begin
      rd_addr = 2'(a);
      #1;
      total++;
      if (rd_data !== exp_rd[a]) begin
        bad++; $display("FAIL reset_rd[%0d] got=%h want=%h", a, rd_data, exp_rd[a]);
      end
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++;
    if (wr_count !== 16'd0) begin bad++; $display("FAIL reset_wr_count got=%0d want=0", wr_count); end
    total++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      bad++; $display("FAIL reset_ready got=%b want=00", {req0_ready, req1_ready});
    end
  endtask

  task automatic test_single_burst();
    req0_valid = 1; req0_addr = 1; req0_data = 32'h0000_0001; req0_last = 0;
    #1;
    total++;
    if (req0_ready !== 1'b0) begin bad++; $display("FAIL burst_ready_early got=%b want=0", req0_ready); end
    tick();
    total++;
    if (req0_ready !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL burst_grant got ready=%b busy=%b want 1 1", req0_ready, busy);
    end
    tick();
    req0_addr = 2; req0_data = 32'h0000_0002;
    rd_addr = 2;
    #1;
    total++;
    if (rd_data !== 32'h0) begin bad++; $display("FAIL no_bypass got=%h want=0", rd_data); end
    tick();
    req0_addr = 3; req0_data = 32'hFFFF_FFFF; req0_last = 1;
    tick();
    req0_valid = 0; req0_last = 0;
    total++;
    if (busy !== 1'b0 || req0_ready !== 1'b0) begin
      bad++; $display("FAIL burst_end got busy=%b ready=%b want 0 0", busy, req0_ready);
    end
    total++;
    if (wr_count !== 16'd3) begin bad++; $display("FAIL burst_count got=%0d want=3", wr_count); end
    rd_addr = 1; #1; total++;
    if (rd_data !== 32'h1) begin bad++; $display("FAIL burst_rd1 got=%h want=1", rd_data); end
    rd_addr = 2; #1; total++;
    if (rd_data !== 32'h2) begin bad++; $display("FAIL burst_rd2 got=%h want=2", rd_data); end
    rd_addr = 3; #1; total++;
    if (rd_data !== 32'hFFFF_FFFF) begin bad++; $display("FAIL burst_rd3 got=%h want=ffffffff", rd_data); end
  endtask

  task automatic test_contention();
    logic [31:0] exp_rd [4];
    exp_rd = '{32'hC0, 32'hA1, 32'hB0, 32'hB1};
    do_reset();
    req0_valid = 1; req0_addr = 0; req0_data = 32'hA0; req0_last = 0;
    req1_valid = 1; req1_addr = 2; req1_data = 32'hB0; req1_last = 0;
    tick();
    total++;
    if ({req0_ready, req1_ready, owner} !== 3'b100) begin
      bad++; $display("FAIL rr_first got r0/r1/own=%b want=100", {req0_ready, req1_ready, owner});
    end
    tick();
    req0_addr = 1; req0_data = 32'hA1; req0_last = 1;
    tick();
    total++;
    if ({busy, req0_ready, req1_ready} !== 3'b000) begin
      bad++; $display("FAIL rr_dead got busy/r0/r1=%b want=000", {busy, req0_ready, req1_ready});
    end
    req0_addr = 0; req0_data = 32'hC0; req0_last = 1;
    tick();
    total++;
    if ({req0_ready, req1_ready, owner} !== 3'b011) begin
      bad++; $display("FAIL rr_second got r0/r1/own=%b want=011", {req0_ready, req1_ready, owner});
    end
    tick();
    req1_addr = 3; req1_data = 32'hB1; req1_last = 1;
    tick();
    req1_valid = 0; req1_last = 0;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL rr_dead2 got busy=%b want=0", busy); end
    tick();
    total++;
    if ({req0_ready, owner} !== 2'b10) begin
      bad++; $display("FAIL rr_third got r0/own=%b want=10", {req0_ready, owner});
    end
    tick();
    req0_valid = 0; req0_last = 0;
    total++;
    if (wr_count !== 16'd5) begin bad++; $display("FAIL rr_count got=%0d want=5", wr_count); end
    for (int a = 0; a < 4; a++) begin
      rd_addr = 2'(a);
      #1;
      total++;
      if (rd_data !== exp_rd[a]) begin
        bad++; $display("FAIL rr_rd[%0d] got=%h want=%h", a, rd_data, exp_rd[a]);
      end
    end
  endtask

  task automatic test_watchdog();
    req1_valid = 1; req1_addr = 0; req1_data = 32'd7; req1_last = 0;
    req0_valid = 1; req0_addr = 1; req0_data = 32'h55; req0_last = 1;
    tick();
    total++;
    if (req1_ready !== 1'b1) begin bad++; $display("FAIL wd_grant got=%b want=1", req1_ready); end
    tick();
    req1_valid = 0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      total++;
      if (req1_ready !== 1'b1) begin bad++; $display("FAIL wd_hold[%0d] got=%b want=1", k, req1_ready); end
    end
    tick();
    total++;
    if (req1_ready !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL wd_revoke got ready=%b busy=%b want 0 0", req1_ready, busy);
    end
    rd_addr = 0; #1; total++;
    if (rd_data !== 32'd7) begin bad++; $display("FAIL wd_bank0 got=%h want=7", rd_data); end
    tick();
    total++;
    if ({req0_ready, owner} !== 2'b10) begin
      bad++; $display("FAIL wd_next got r0/own=%b want=10", {req0_ready, owner});
    end
    tick();
    req0_valid = 0; req0_last = 0;
    rd_addr = 1; #1; total++;
    if (rd_data !== 32'h55) begin bad++; $display("FAIL wd_bank1 got=%h want=55", rd_data); end
  endtask

  task automatic test_reset_mid_burst();
    req0_valid = 1; req0_addr = 2; req0_data = 32'h11; req0_last = 0;
    tick();
    tick();
    req0_addr = 3; req0_data = 32'h22;
    #2;
    reset = 1;
    #1;
    total++;
    if ({req0_ready, busy} !== 2'b00) begin
      bad++; $display("FAIL async_reset got ready/busy=%b want=00", {req0_ready, busy});
    end
    total++;
    if (wr_count !== 16'd0) begin bad++; $display("FAIL async_count got=%0d want=0", wr_count); end
    for (int a = 0; a < 4; a++) begin
      rd_addr = 2'(a);
      #1;
      total++;
      if (rd_data !== 32'h0) begin bad++; $display("FAIL async_rd[%0d] got=%h want=0", a, rd_data); end
    end
    req0_valid = 0;
    @(negedge clk);
    reset = 0;
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    req0_valid = 1; req0_addr = 2; req0_data = 0; req0_last = 0;
    tick();
    for (int i = 0; i < 65536; i++) begin
      req0_data = 32'(i);
      req0_last = (i == 65535);
      tick();
    end
    req0_valid = 0; req0_last = 0;
    total++;
    if (wr_count !== 16'd0) begin bad++; $display("FAIL wrap_zero got=%0d want=0", wr_count); end
    rd_addr = 2; #1; total++;
    if (rd_data !== 32'd65535) begin bad++; $display("FAIL wrap_last_wins got=%h want=ffff", rd_data); end
    req0_valid = 1; req0_addr = 3; req0_data = 32'h99; req0_last = 1;
    tick();
    tick();
    req0_valid = 0; req0_last = 0;
    total++;
    if (wr_count !== 16'd1) begin bad++; $display("FAIL wrap_one got=%0d want=1", wr_count); end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_contention();
    test_watchdog();
    test_reset_mid_burst();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
